shared_counter_sched: RTL and testbench
=======================================

// Module: shared_counter_sched
//
// PURPOSE
//   Round-robin scheduler that shares one WIDTH-bit up-counter (add-by-one + register
//   datapath) among N_REQ requesters. Each requester asks for a count run of its own
//   length. The winner holds the counter until its run ends, then gets a one-cycle done.
//   Sits between timing clients and the shared counter datapath; the only writer of it.
//
// PARAMETERS
//   N_REQ  4  number of requesters (>=2)
//   WIDTH  4  counter / length width in bits
//
// PORTS
//   CLK      in   1            rising-edge clock
//   RESETN   in   1            asynchronous, active-low reset
//   REQ      in   N_REQ        per-requester request level; held high for the whole run
//   LEN      in   N_REQ*WIDTH  per-requester terminal count; slice i = LEN[i*WIDTH +: WIDTH]
//   GNT      out  N_REQ        one-hot grant, high for the whole RUN state
//   BUSY     out  1            high while the state is not IDLE
//   COUNT    out  WIDTH        shared counter value (0 outside RUN)
//   DONE     out  1            one-cycle pulse: run completed normally
//   DONE_ID  out  clog2(N_REQ) index of the completed requester; valid only with DONE
//
// BEHAVIOUR
//   - Reset (RESETN low, async): state=IDLE, GNT=0, BUSY=0, COUNT=0, DONE=0, DONE_ID=0,
//     rr pointer=0 (req 0 highest priority). Reset mid-run aborts the run silently.
//   - FSM states: IDLE, RUN, DONE.
//   - IDLE: if any REQ is high at edge t, pick the first set bit at or after ptr, wrapping
//     modulo N_REQ; latch its LEN slice into len_q. At t+1: state=RUN, GNT one-hot for
//     the winner, COUNT=0. ptr := winner+1 mod N_REQ, updated at the grant.
//   - RUN: COUNT increments by 1 each cycle. Non-wrapping add; WIDTH-bit adder, carry unused.
//     - If COUNT==len_q, the next edge goes to DONE.
//     - RUN therefore lasts len_q+1 cycles; LEN=0 gives one RUN cycle.
//     - len_q is the full range 0..2^WIDTH-1, so COUNT never wraps.
//   - Abort: granted REQ low during RUN, sampled at an edge.
//     - Next cycle: state=IDLE, GNT=0, COUNT=0, no DONE.
//     - Abort takes priority over reaching terminal count in the same cycle.
//   - DONE: one cycle. DONE=1, DONE_ID=winner, GNT=0, COUNT=0, BUSY=1. Next state is IDLE
//     unconditionally.
//   - Minimum spacing between the end of RUN and the next GNT is 2 cycles (DONE, IDLE).
//   - Changes to LEN or REQ of other requesters during RUN have no effect (len_q latched).
//   - All outputs are registered; no combinational path from inputs to outputs.
//
// STRUCTURE
//   - Shared package: state enum {IDLE=2'd0, RUN=2'd1, DONE=2'd2}, and an IDX_W = clog2(N_REQ)
//     helper.
//   - One sub-module: rr_pick. Combinational priority rotate from (req, ptr) to
//     (valid, idx, onehot).
//   - Counter register, len_q, ptr and FSM live in the top.
//
// TESTING
//   1. N_REQ=4, WIDTH=4. REQ=0001, LEN0=3 -> GNT=0001 one cycle after REQ.
//      COUNT 0,1,2,3 -> DONE=1 with DONE_ID=0 -> IDLE.
//   2. REQ=1111 held, all LEN=0 -> grants rotate 0,1,2,3,0. Each is 1 RUN cycle + DONE + IDLE;
//      DONE_IDs follow the same order.
//   3. REQ=0101, LEN2=15 after a grant to 0 -> next grant goes to 2. COUNT reaches 15 with no
//      wrap; DONE_ID=2.
//   4. Grant to 1 with LEN1=9; drop REQ[1] when COUNT=4 -> next cycle GNT=0, COUNT=0,
//      BUSY=0, DONE never pulses. ptr still advanced to 2.
//   5. Assert RESETN low asynchronously mid-RUN (between edges) -> all outputs 0
//      immediately. After release with REQ=1010, first grant goes to 1.
//   6. Drop REQ on the same edge COUNT==len_q -> abort wins, no DONE.

Source files
------------

// File: rtl/shared_counter_sched_pkg.sv
// Shared types and sizing helpers for the round-robin counter scheduler.
package shared_counter_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_counter_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import shared_counter_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] pos [N_REQ];

  // pos[gi] is the requester index gi places after ptr, modulo N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    assign sum     = {1'b0, ptr} + (IDX_W+1)'(gi);
    assign pos[gi] = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                                 : sum[IDX_W-1:0];
    assign rot[gi] = req[pos[gi]];
  end

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        idx   = pos[k];
      end
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/shared_counter_sched.sv
// Round-robin scheduler owning one shared up-counter; each winner counts 0..LEN then
// gets a one-cycle DONE. Dropping the request mid-run aborts without DONE.
module shared_counter_sched
  import shared_counter_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 4,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*WIDTH-1:0] LEN,
  output logic [N_REQ-1:0]       GNT,
  output logic                   BUSY,
  output logic [WIDTH-1:0]       COUNT,
  output logic                   DONE,
  output logic [IDX_W-1:0]       DONE_ID
);

  state_t           state_reg;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] count_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] winner_reg;
  logic [IDX_W-1:0] done_id_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] ptr_next;
  logic [WIDTH-1:0] len_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_len
    assign len_arr[gi] = LEN[gi*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (REQ),
    .ptr    (ptr_reg),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign ptr_next = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg   <= S_IDLE;
      len_q       <= '0;
      count_reg   <= '0;
      ptr_reg     <= '0;
      winner_reg  <= '0;
      done_id_reg <= '0;
      gnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (pick_valid) begin
            state_reg  <= S_RUN;
            len_q      <= len_arr[pick_idx];
            winner_reg <= pick_idx;
            ptr_reg    <= ptr_next;
            gnt_reg    <= pick_onehot;
            busy_reg   <= 1'b1;
            count_reg  <= '0;
          end
        end
        S_RUN: begin
          // Abort is checked first so it beats terminal count on the same edge.
          if (!REQ[winner_reg]) begin
            state_reg <= S_IDLE;
            gnt_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
          end else if (count_reg == len_q) begin
            state_reg   <= S_DONE;
            gnt_reg     <= '0;
            count_reg   <= '0;
            done_reg    <= 1'b1;
            done_id_reg <= winner_reg;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          gnt_reg   <= '0;
          count_reg <= '0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT     = gnt_reg;
  assign BUSY    = busy_reg;
  assign COUNT   = count_reg;
  assign DONE    = done_reg;
  assign DONE_ID = done_id_reg;

endmodule

// File: tb/tb_shared_counter_sched.sv
// Directed bench for shared_counter_sched: grants, rotation, long runs, aborts and reset.
module tb_shared_counter_sched;

  logic        CLK;
  logic        RESETN;
  logic [3:0]  REQ;
  logic [15:0] LEN;
  logic [3:0]  GNT;
  logic        BUSY;
  logic [3:0]  COUNT;
  logic        DONE;
  logic [1:0]  DONE_ID;

  logic [9:0]  obs;
  logic [9:0]  exp_v;
  int          checks;
  int          errors;

  shared_counter_sched #(
    .N_REQ (4),
    .WIDTH (4)
  ) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .REQ     (REQ),
    .LEN     (LEN),
    .GNT     (GNT),
    .BUSY    (BUSY),
    .COUNT   (COUNT),
    .DONE    (DONE),
    .DONE_ID (DONE_ID)
  );

  // Observation vector: {GNT, BUSY, COUNT, DONE}
  assign obs = {GNT, BUSY, COUNT, DONE};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset;
    REQ    = '0;
    LEN    = '0;
    RESETN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
  endtask

  task automatic test_reset;
    REQ    = '0;
    LEN    = '0;
    RESETN = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required %b", obs, 10'd0);
    end
    checks++;
    if (DONE_ID !== 2'd0) begin
      errors++;
      $display("FAIL reset_done_id: got %0d required 0", DONE_ID);
    end
    RESETN = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    LEN[3:0] = 4'd3;
    REQ      = 4'b0001;
    tick();
    exp_v = {4'b0001, 1'b1, 4'd0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_grant: got %b required %b", obs, exp_v);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_v = {4'b0001, 1'b1, 4'(k), 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single_count%0d: got %b required %b", k, obs, exp_v);
      end
    end
    tick();
    exp_v = {4'b0000, 1'b1, 4'd0, 1'b1};
    checks++;
    if (obs !== exp_v || DONE_ID !== 2'd0) begin
      errors++;
      $display("FAIL single_done: got %b id %0d required %b id 0", obs, DONE_ID, exp_v);
    end
    REQ = '0;
    tick();
    checks++;
    if (obs !== 10'd0) begin
      errors++;
      $display("FAIL single_idle: got %b required %b", obs, 10'd0);
    end
  endtask

  task automatic test_rotate;
    int id;
    do_reset();
    REQ = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      id = n % 4;
      tick();
      exp_v = {4'(1 << id), 1'b1, 4'd0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rotate_grant%0d: got %b required %b", n, obs, exp_v);
      end
      tick();
      exp_v = {4'b0000, 1'b1, 4'd0, 1'b1};
      checks++;
      if (obs !== exp_v || DONE_ID !== 2'(id)) begin
        errors++;
        $display("FAIL rotate_done%0d: got %b id %0d required %b id %0d",
                 n, obs, DONE_ID, exp_v, id);
      end
      tick();
      checks++;
      if (obs !== 10'd0) begin
        errors++;
        $display("FAIL rotate_idle%0d: got %b required %b", n, obs, 10'd0);
      end
    end
    REQ = '0;
    tick();
  endtask

  task automatic test_long;
    do_reset();
    LEN[11:8] = 4'd15;
    REQ       = 4'b0101;
    tick();
    exp_v = {4'b0001, 1'b1, 4'd0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL long_first_grant: got %b required %b", obs, exp_v);
    end
    tick();
    tick();
    tick();
    exp_v = {4'b0100, 1'b1, 4'd0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL long_grant2: got %b required %b", obs, exp_v);
    end
    // A LEN change after the grant must not shorten the run.
    LEN[11:8] = 4'd3;
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp_v = {4'b0100, 1'b1, 4'(k), 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL long_count%0d: got %b required %b", k, obs, exp_v);
      end
    end
    tick();
    exp_v = {4'b0000, 1'b1, 4'd0, 1'b1};
    checks++;
    if (obs !== exp_v || DONE_ID !== 2'd2) begin
      errors++;
      $display("FAIL long_done: got %b id %0d required %b id 2", obs, DONE_ID, exp_v);
    end
    REQ = '0;
    tick();
  endtask

  task automatic test_abort;
    do_reset();
    LEN[7:4] = 4'd9;
    REQ      = 4'b0010;
    tick();
    exp_v = {4'b0010, 1'b1, 4'd0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL abort_grant: got %b required %b", obs, exp_v);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_v = {4'b0010, 1'b1, 4'(k), 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL abort_count%0d: got %b required %b", k, obs, exp_v);
      end
    end
    REQ = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== 10'd0) begin
        errors++;
        $display("FAIL abort_quiet%0d: got %b required %b", k, obs, 10'd0);
      end
    end
    REQ = 4'b0111;
    tick();
    exp_v = {4'b0100, 1'b1, 4'd0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL abort_ptr_advance: got %b required %b", obs, exp_v);
    end
    REQ = '0;
    tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    LEN[11:8] = 4'd5;
    REQ       = 4'b0100;
    tick();
    tick();
    exp_v = {4'b0100, 1'b1, 4'd1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL async_prerun: got %b required %b", obs, exp_v);
    end
    #2;
    RESETN = 1'b0;
    #1;
    checks++;
    if (obs !== 10'd0 || DONE_ID !== 2'd0) begin
      errors++;
      $display("FAIL async_reset_now: got %b id %0d required %b id 0", obs, DONE_ID, 10'd0);
    end
    @(negedge CLK);
    RESETN = 1'b1;
    REQ    = 4'b1010;
    tick();
    exp_v = {4'b0010, 1'b1, 4'd0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL async_first_grant: got %b required %b", obs, exp_v);
    end
    REQ = '0;
    tick();
  endtask

  task automatic test_abort_terminal;
    do_reset();
    LEN[3:0] = 4'd2;
    REQ      = 4'b0001;
    tick();
    tick();
    tick();
    exp_v = {4'b0001, 1'b1, 4'd2, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL term_at_len: got %b required %b", obs, exp_v);
    end
    REQ = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (obs !== 10'd0) begin
        errors++;
        $display("FAIL term_abort%0d: got %b required %b", k, obs, 10'd0);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_rotate();
    test_long();
    test_abort();
    test_async_reset();
    test_abort_terminal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
